// File: rtl/vram_fill_arbiter.sv
// Sole VRAM write master: arbitrates single-byte VRAM writes between CPU direct
// writes and a clipped rectangle-fill engine that writes two 4bpp pixels per byte.
module vram_fill_arbiter #(
   parameter int WIDTH              = 128,
   parameter int HEIGHT             = 128,
   parameter int VRAM_ADDRESS_WIDTH = $clog2((WIDTH*HEIGHT+1)>>1)
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_cpu_valid,
   input  logic [VRAM_ADDRESS_WIDTH-1:0] i_cpu_adr,
   input  logic [7:0]                    i_cpu_data,
   output logic                          o_cpu_ready,
   input  logic                          i_cmd_valid,
   input  logic [33:0]                   i_cmd_bits,
   output logic                          o_cmd_ready,
   output logic                          o_vram_valid,
   output logic [VRAM_ADDRESS_WIDTH-1:0] o_vram_adr,
   output logic [7:0]                    o_vram_data,
   input  logic                          i_vram_ready,
   output logic                          o_busy,
   output logic                          o_done
);

   localparam int         VAW      = VRAM_ADDRESS_WIDTH;
   localparam logic [8:0] WIDTH_9  = 9'(WIDTH);
   localparam logic [8:0] HEIGHT_9 = 9'(HEIGHT);

   typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

   state_t     state;
   logic [8:0] x0, y0, w, h;
   logic [3:0] color;
   logic [8:0] xs, xe, ye, x, y;
   logic       grant_cpu;
   logic       last_cpu;

   logic [8:0]     x_sum, y_sum, x_clip, xs_calc, xe_calc, ye_calc;
   logic           fill_req, cpu_wins, handshake;
   logic [VAW-1:0] fill_adr;

   // Nine-bit sums so x0+w and y0+h never wrap before clipping.
   assign x_sum   = x0 + w;
   assign y_sum   = y0 + h;
   assign x_clip  = (x_sum > WIDTH_9) ? WIDTH_9 : x_sum;
   assign xs_calc = x0 & ~9'd1;
   assign xe_calc = (x_clip + 9'd1) & ~9'd1;
   assign ye_calc = (y_sum > HEIGHT_9) ? HEIGHT_9 : y_sum;

   assign fill_req    = (state == FILL);
   assign cpu_wins    = i_cpu_valid && (!fill_req || !last_cpu);
   assign handshake   = o_vram_valid && i_vram_ready;
   assign o_cpu_ready = handshake && grant_cpu;
   assign fill_adr    = VAW'((32'(y) * 32'(WIDTH) + 32'(x)) >> 1);

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         x0           <= '0;
         y0           <= '0;
         w            <= '0;
         h            <= '0;
         color        <= '0;
         xs           <= '0;
         xe           <= '0;
         ye           <= '0;
         x            <= '0;
         y            <= '0;
         grant_cpu    <= 1'b0;
         last_cpu     <= 1'b1;
         o_cmd_ready  <= 1'b0;
         o_vram_valid <= 1'b0;
         o_vram_adr   <= '0;
         o_vram_data  <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
      end else begin
         o_cmd_ready <= 1'b0;
         o_done      <= 1'b0;

         // Grant is locked while valid is high; a new one is chosen only in a valid-low cycle.
         if (handshake) begin
            o_vram_valid <= 1'b0;
         end else if (!o_vram_valid && (fill_req || i_cpu_valid)) begin
            o_vram_valid <= 1'b1;
            grant_cpu    <= cpu_wins;
            last_cpu     <= cpu_wins;
            o_vram_adr   <= cpu_wins ? i_cpu_adr : fill_adr;
            o_vram_data  <= cpu_wins ? i_cpu_data : {color, color};
         end

         case (state)
            IDLE: begin
               if (i_cmd_valid) begin
                  x0          <= {2'b00, i_cmd_bits[6:0]};
                  y0          <= {2'b00, i_cmd_bits[13:7]};
                  w           <= {1'b0, i_cmd_bits[21:14]};
                  h           <= {1'b0, i_cmd_bits[29:22]};
                  color       <= i_cmd_bits[33:30];
                  o_cmd_ready <= 1'b1;
                  o_busy      <= 1'b1;
                  state       <= SETUP;
               end
            end
            SETUP: begin
               xs <= xs_calc;
               xe <= xe_calc;
               ye <= ye_calc;
               x  <= xs_calc;
               y  <= y0;
               if (xs_calc >= xe_calc || y0 >= ye_calc) state <= DONE;
               else                                     state <= FILL;
            end
            FILL: begin
               if (handshake && !grant_cpu) begin
                  if (x + 9'd2 == xe) begin
                     x <= xs;
                     y <= y + 9'd1;
                     if (y + 9'd1 == ye) state <= DONE;
                  end else begin
                     x <= x + 9'd2;
                  end
               end
            end
            DONE: begin
               o_done <= 1'b1;
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_fill_arbiter.sv
// Randomised bench for vram_fill_arbiter: every VRAM beat is logged and compared
// against a rectangle model computed directly from the clipping rules.
module tb_vram_fill_arbiter;

   localparam int W   = 128;
   localparam int H   = 128;
   localparam int VAW = 13;

   typedef logic [VAW+7:0] beat_t;

   logic           i_clk = 1'b0;
   logic           i_rst = 1'b1;
   logic           i_cpu_valid = 1'b0;
   logic [VAW-1:0] i_cpu_adr = '0;
   logic [7:0]     i_cpu_data = '0;
   logic           o_cpu_ready;
   logic           i_cmd_valid = 1'b0;
   logic [33:0]    i_cmd_bits = '0;
   logic           o_cmd_ready;
   logic           o_vram_valid;
   logic [VAW-1:0] o_vram_adr;
   logic [7:0]     o_vram_data;
   logic           i_vram_ready = 1'b0;
   logic           o_busy;
   logic           o_done;

   vram_fill_arbiter #(.WIDTH(W), .HEIGHT(H)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_cpu_valid (i_cpu_valid),
      .i_cpu_adr   (i_cpu_adr),
      .i_cpu_data  (i_cpu_data),
      .o_cpu_ready (o_cpu_ready),
      .i_cmd_valid (i_cmd_valid),
      .i_cmd_bits  (i_cmd_bits),
      .o_cmd_ready (o_cmd_ready),
      .o_vram_valid(o_vram_valid),
      .o_vram_adr  (o_vram_adr),
      .o_vram_data (o_vram_data),
      .i_vram_ready(i_vram_ready),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 i_clk = ~i_clk;

   int    vectors = 0;
   int    miscompares = 0;
   int    cyc = 0;
   int    done_cnt, unstable_cnt, last_done_cyc, last_rdy_cyc;
   int    ready_mode = 0;            // 0: always ready, 1: random, 2: never
   bit    busy_seen, cpu_keep, cpu_hs_pending;
   beat_t fill_q[$], cpu_q[$], exp_q[$], cpu_exp_q[$];
   bit    src_q[$];                  // per beat: 1 = CPU, 0 = fill
   logic           prev_valid = 1'b0, prev_hs = 1'b0;
   logic [VAW-1:0] prev_adr;
   logic [7:0]     prev_data;

   task automatic cpu_issue();
      i_cpu_adr   = VAW'($urandom);
      i_cpu_data  = 8'($urandom);
      i_cpu_valid = 1'b1;
      cpu_exp_q.push_back({i_cpu_adr, i_cpu_data});
   endtask

   // One clock: update drivers after the edge, then sample outputs mid-cycle.
   task automatic cycle();
      @(negedge i_clk);
      if (cpu_hs_pending) begin
         cpu_hs_pending = 1'b0;
         if (cpu_keep) cpu_issue();
         else          i_cpu_valid = 1'b0;
      end
      case (ready_mode)
         0:       i_vram_ready = 1'b1;
         1:       i_vram_ready = ($urandom_range(0, 2) != 0);
         default: i_vram_ready = 1'b0;
      endcase
      #1;
      cyc++;
      if (o_vram_valid && prev_valid && !prev_hs &&
          (o_vram_adr !== prev_adr || o_vram_data !== prev_data)) unstable_cnt++;
      if (o_vram_valid && i_vram_ready) begin
         src_q.push_back(o_cpu_ready);
         if (o_cpu_ready) cpu_q.push_back({o_vram_adr, o_vram_data});
         else             fill_q.push_back({o_vram_adr, o_vram_data});
      end
      if (o_cpu_ready) cpu_hs_pending = 1'b1;
      if (o_done) begin done_cnt++; last_done_cyc = cyc; end
      if (o_cmd_ready) last_rdy_cyc = cyc;
      if (o_busy) busy_seen = 1'b1;
      prev_valid = o_vram_valid;
      prev_hs    = o_vram_valid && i_vram_ready;
      prev_adr   = o_vram_adr;
      prev_data  = o_vram_data;
   endtask

   task automatic clear_logs();
      fill_q.delete(); cpu_q.delete(); exp_q.delete(); cpu_exp_q.delete(); src_q.delete();
      done_cnt = 0; unstable_cnt = 0; busy_seen = 1'b0;
      last_done_cyc = -100; last_rdy_cyc = 0;
   endtask

   task automatic start_fill(input logic [3:0] c, input int x0, input int y0, input int w, input int h);
      i_cmd_bits  = {c, 8'(h), 8'(w), 7'(y0), 7'(x0)};
      i_cmd_valid = 1'b1;
      cycle();
      i_cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit timed_out);
      int start;
      start = done_cnt;
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (done_cnt != start) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   // Rectangle model: even-aligned start, clipped end rounded up to even.
   task automatic build_model(input logic [3:0] c, input int x0, input int y0, input int w, input int h);
      int xs, xe, ye;
      exp_q.delete();
      xs = x0 - (x0 % 2);
      xe = (x0 + w < W) ? x0 + w : W;
      if (xe % 2 != 0) xe++;
      ye = (y0 + h < H) ? y0 + h : H;
      for (int yy = y0; yy < ye; yy++)
         for (int xx = xs; xx < xe; xx += 2)
            exp_q.push_back({VAW'((yy * W + xx) / 2), c, c});
   endtask

   function automatic int first_diff(input beat_t a[$], input beat_t b[$]);
      int n;
      n = (a.size() < b.size()) ? a.size() : b.size();
      for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
      return (a.size() == b.size()) ? -1 : n;
   endfunction

   task automatic test_reset();
      ready_mode = 0;
      i_rst = 1'b1;
      cycle(); cycle();
      vectors++;
      if ({o_cpu_ready, o_cmd_ready, o_vram_valid, o_busy, o_done} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b want 00000", {o_cpu_ready, o_cmd_ready, o_vram_valid, o_busy, o_done});
      end
      vectors++;
      if ({o_vram_adr, o_vram_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got adr %0d data %h want 0/0", o_vram_adr, o_vram_data);
      end
      i_rst = 1'b0;
      clear_logs();
      for (int i = 0; i < 10; i++) cycle();
      vectors++;
      if (fill_q.size() + cpu_q.size() + done_cnt + int'(busy_seen) != 0) begin
         miscompares++;
         $display("FAIL reset_idle: got %0d writes %0d done busy %0b want none", fill_q.size() + cpu_q.size(), done_cnt, busy_seen);
      end
   endtask

   task automatic test_basic_fill();
      bit to;
      clear_logs();
      ready_mode = 0;
      start_fill(4'd5, 4, 2, 4, 2);
      wait_done(200, to);
      for (int i = 0; i < 5; i++) cycle();
      exp_q.push_back({13'd130, 8'h55}); exp_q.push_back({13'd131, 8'h55});
      exp_q.push_back({13'd194, 8'h55}); exp_q.push_back({13'd195, 8'h55});
      vectors++;
      if (to || first_diff(exp_q, fill_q) != -1) begin
         miscompares++;
         $display("FAIL basic_writes: got %0d writes (timeout %0b) first diff %0d want 4 writes 130,131,194,195 data 55", fill_q.size(), to, first_diff(exp_q, fill_q));
      end
      vectors++;
      if (done_cnt != 1 || !busy_seen || o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_status: got done %0d busy_seen %0b busy_after %b want 1 1 0", done_cnt, busy_seen, o_busy);
      end
   endtask

   task automatic test_clip();
      bit to;
      clear_logs();
      ready_mode = 1;
      start_fill(4'hA, 126, 127, 10, 10);
      wait_done(200, to);
      exp_q.push_back({13'd8191, 8'hAA});
      vectors++;
      if (to || first_diff(exp_q, fill_q) != -1) begin
         miscompares++;
         $display("FAIL clip_corner: got %0d writes first %h want 1 write adr 8191 data aa", fill_q.size(), (fill_q.size() > 0) ? fill_q[0] : '0);
      end
      clear_logs();
      start_fill(4'h3, 3, 9, 1, 1);
      wait_done(200, to);
      exp_q.push_back({13'd577, 8'h33});
      vectors++;
      if (to || first_diff(exp_q, fill_q) != -1) begin
         miscompares++;
         $display("FAIL clip_odd: got %0d writes first %h want 1 write adr 577 data 33", fill_q.size(), (fill_q.size() > 0) ? fill_q[0] : '0);
      end
   endtask

   task automatic test_empty();
      bit to;
      int dims[2][2] = '{'{0, 4}, '{4, 0}};
      for (int k = 0; k < 2; k++) begin
         clear_logs();
         ready_mode = 0;
         start_fill(4'h7, 10, 5, dims[k][0], dims[k][1]);
         wait_done(50, to);
         vectors++;
         if (to || fill_q.size() != 0 || last_done_cyc - last_rdy_cyc != 2) begin
            miscompares++;
            $display("FAIL empty_%0d: got %0d writes done-ready gap %0d (timeout %0b) want 0 writes gap 2", k, fill_q.size(), last_done_cyc - last_rdy_cyc, to);
         end
      end
   endtask

   task automatic test_random_fills();
      bit to;
      int x0, y0, w, h;
      logic [3:0] c;
      for (int n = 0; n < 10; n++) begin
         clear_logs();
         ready_mode = 1;
         x0 = $urandom_range(0, 127); y0 = $urandom_range(0, 127);
         w  = $urandom_range(0, 40);  h  = $urandom_range(0, 6);
         c  = 4'($urandom);
         build_model(c, x0, y0, w, h);
         start_fill(c, x0, y0, w, h);
         wait_done(3000, to);
         vectors++;
         if (to || first_diff(exp_q, fill_q) != -1 || done_cnt != 1 || unstable_cnt != 0) begin
            miscompares++;
            $display("FAIL random_fill_%0d: x0 %0d y0 %0d w %0d h %0d got %0d writes want %0d first diff %0d done %0d unstable %0d timeout %0b",
                     n, x0, y0, w, h, fill_q.size(), exp_q.size(), first_diff(exp_q, fill_q), done_cnt, unstable_cnt, to);
         end
      end
   endtask

   task automatic test_cpu_interleave();
      bit to;
      bit drained;
      int first, last, viol;
      clear_logs();
      ready_mode = 1;
      cpu_keep = 1'b1;
      cpu_issue();
      build_model(4'hC, 20, 40, 16, 3);
      start_fill(4'hC, 20, 40, 16, 3);
      wait_done(3000, to);
      cpu_keep = 1'b0;
      drained = 1'b0;
      for (int i = 0; i < 50 && !drained; i++) begin
         cycle();
         drained = !i_cpu_valid;
      end
      vectors++;
      if (to || !drained || first_diff(exp_q, fill_q) != -1) begin
         miscompares++;
         $display("FAIL interleave_fill: got %0d fill writes want %0d first diff %0d timeout %0b drained %0b", fill_q.size(), exp_q.size(), first_diff(exp_q, fill_q), to, drained);
      end
      vectors++;
      if (first_diff(cpu_exp_q, cpu_q) != -1) begin
         miscompares++;
         $display("FAIL interleave_cpu: got %0d cpu writes want %0d first diff %0d", cpu_q.size(), cpu_exp_q.size(), first_diff(cpu_exp_q, cpu_q));
      end
      first = -1; last = -1; viol = 0;
      foreach (src_q[i]) if (!src_q[i]) begin
         if (first < 0) first = i;
         last = i;
      end
      for (int i = first; i < last; i++) if (src_q[i] == src_q[i+1]) viol++;
      vectors++;
      if (viol != 0 || unstable_cnt != 0) begin
         miscompares++;
         $display("FAIL interleave_order: got %0d repeated-source beats %0d unstable cycles want 0 0", viol, unstable_cnt);
      end
   endtask

   task automatic test_reset_midfill();
      bit to;
      bit seen;
      clear_logs();
      ready_mode = 0;
      start_fill(4'h9, 0, 0, 64, 4);
      for (int i = 0; i < 100 && fill_q.size() < 3; i++) cycle();
      ready_mode = 2;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         cycle();
         seen = o_vram_valid;
      end
      i_rst = 1'b1;
      cycle();
      vectors++;
      if (!seen || o_vram_valid !== 1'b0 || o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midfill_reset: got valid %b busy %b (beat4 locked %0b) want 0 0 1", o_vram_valid, o_busy, seen);
      end
      i_rst = 1'b0;
      ready_mode = 0;
      for (int i = 0; i < 10; i++) cycle();
      vectors++;
      if (fill_q.size() != 3 || done_cnt != 0) begin
         miscompares++;
         $display("FAIL midfill_quiet: got %0d writes %0d done want 3 0", fill_q.size(), done_cnt);
      end
      clear_logs();
      build_model(4'h2, 4, 2, 4, 2);
      start_fill(4'h2, 4, 2, 4, 2);
      wait_done(200, to);
      vectors++;
      if (to || first_diff(exp_q, fill_q) != -1 || done_cnt != 1) begin
         miscompares++;
         $display("FAIL midfill_recover: got %0d writes done %0d timeout %0b want %0d writes done 1", fill_q.size(), done_cnt, to, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_clip();
      test_empty();
      test_random_fills();
      test_cpu_interleave();
      test_reset_midfill();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
